// File: rtl/muldiv_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, op, op1, op2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, op1, op2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with early completion for the
// divide special cases and an optional single-cycle multiplier.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit FAST_MUL   = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  // Iteration 0 runs on the accept edge, so the last busy edge carries counter W-2.
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 2);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic {IDLE, BUSY} state_e;

  // One radix-2 step. Multiply: {hi,lo} is the partial product with the multiplier
  // shifting out of lo. Divide: hi is the partial remainder, lo shifts the dividend
  // out at the top and collects quotient bits at the bottom.
  function automatic logic [2*W-1:0] iter_step(input logic         is_div,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] hi,
                                               input logic [W-1:0] lo);
    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [W-1:0] nhi;
    logic [W-1:0] nlo;
    if (is_div) begin
      trial = {hi, lo[W-1]} - {1'b0, a};
      if (!trial[W]) begin
        nhi = trial[W-1:0];
        nlo = {lo[W-2:0], 1'b1};
      end else begin
        nhi = {hi[W-2:0], lo[W-1]};
        nlo = {lo[W-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(W+1){1'b0}});
      nhi = sum[W:1];
      nlo = {sum[0], lo[W-1:1]};
    end
    return {nhi, nlo};
  endfunction

  // Apply the result sign and pick the half/quotient/remainder the op asks for.
  function automatic logic [W-1:0] finish_res(input logic [2:0]   op,
                                              input logic         neg,
                                              input logic [W-1:0] hi,
                                              input logic [W-1:0] lo);
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic [W-1:0]   res;
    prod = neg ? -{hi, lo} : {hi, lo};
    quo  = neg ? -lo : lo;
    rem  = neg ? -hi : hi;
    case (op)
      OP_MUL:                       res = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*W-1:W];
      OP_DIV, OP_DIVU:              res = quo;
      default:                      res = rem;
    endcase
    return res;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;

  logic           op1_sgn, op2_sgn, neg_in;
  logic [W-1:0]   mag1, mag2;
  logic           div_zero, div_ovf, fast_hit, special;
  logic [W-1:0]   special_res;
  logic [2*W-1:0] fast_prod;
  logic [W-1:0]   step_hi, step_lo, init_hi, init_lo;

  assign fast_prod = FAST_MUL ? ({{W{1'b0}}, mag1} * {{W{1'b0}}, mag2}) : {(2*W){1'b0}};

  // Decode the incoming request: operand signs, magnitudes and early-completion cases.
  always_comb begin
    op1_sgn  = (bus.op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.op1[W-1];
    op2_sgn  = (bus.op inside {OP_MULH, OP_DIV, OP_REM}) && bus.op2[W-1];
    mag1     = op1_sgn ? -bus.op1 : bus.op1;
    mag2     = op2_sgn ? -bus.op2 : bus.op2;
    // Remainder follows the dividend; everything else takes the product/quotient sign.
    neg_in   = (bus.op == OP_REM) ? op1_sgn : (op1_sgn ^ op2_sgn);
    div_zero = bus.op[2] && (bus.op2 == {W{1'b0}});
    div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.op1 == MOST_NEG) && (bus.op2 == {W{1'b1}});
    fast_hit = !bus.op[2] && FAST_MUL;
    special  = div_zero || div_ovf || fast_hit;
    if (div_zero) begin
      special_res = bus.op[1] ? bus.op1 : {W{1'b1}};
    end else if (div_ovf) begin
      special_res = bus.op[1] ? {W{1'b0}} : MOST_NEG;
    end else begin
      special_res = finish_res(bus.op, neg_in, fast_prod[2*W-1:W], fast_prod[W-1:0]);
    end
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, flush aborts without done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;
    {step_hi, step_lo} = iter_step(op_q[2], a_q, hi_q, lo_q);
    {init_hi, init_lo} = iter_step(bus.op[2], bus.op[2] ? mag2 : mag1,
                                   {W{1'b0}}, bus.op[2] ? mag1 : mag2);
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.op;
          neg_d = neg_in;
          if (special) begin
            result_d = special_res;
            done_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = {CW{1'b0}};
            a_d     = bus.op[2] ? mag2 : mag1;
            hi_d    = init_hi;
            lo_d    = init_lo;
          end
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = IDLE;
            result_d = finish_res(op_q, neg_q, step_hi, step_lo);
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == BUSY);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (W=32, W=32 with FAST_MUL, W=16) share one
// stimulus bus; the selected instance is checked against an arithmetic reference.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  int          sel = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        busy_m, done_m;
  logic [31:0] result_m;

  muldiv_if #(.DATA_WIDTH(32)) if0 ();
  muldiv_if #(.DATA_WIDTH(32)) if1 ();
  muldiv_if #(.DATA_WIDTH(16)) if2 ();

  assign if0.start = start && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if2.start = start && (sel == 2);
  assign if0.op = op;  assign if1.op = op;  assign if2.op = op;
  assign if0.op1 = op1; assign if1.op1 = op1; assign if2.op1 = op1[15:0];
  assign if0.op2 = op2; assign if1.op2 = op2; assign if2.op2 = op2[15:0];
  assign if0.flush = flush; assign if1.flush = flush; assign if2.flush = flush;

  muldiv_unit #(.DATA_WIDTH(32), .FAST_MUL(1'b0)) u_w32  (.clk(clk), .rst_n(rst_n), .bus(if0));
  muldiv_unit #(.DATA_WIDTH(32), .FAST_MUL(1'b1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(if1));
  muldiv_unit #(.DATA_WIDTH(16), .FAST_MUL(1'b0)) u_w16  (.clk(clk), .rst_n(rst_n), .bus(if2));

  always #5 clk = ~clk;

  always_comb begin
    busy_m   = if0.busy;
    done_m   = if0.done;
    result_m = if0.result;
    if (sel == 1) begin
      busy_m   = if1.busy;
      done_m   = if1.done;
      result_m = if1.result;
    end else if (sel == 2) begin
      busy_m   = if2.busy;
      done_m   = if2.done;
      result_m = {16'h0000, if2.result};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    longint unsigned mask, ua, ub, pu, r;
    longint          sa, sb, ps, min_s;
    mask  = (64'd1 << w) - 64'd1;
    ua    = {32'd0, a} & mask;
    ub    = {32'd0, b} & mask;
    sa    = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb    = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    min_s = -(longint'(1) << (w - 1));
    case (o)
      3'd0: r = ua * ub;
      3'd1: begin ps = sa * sb;           r = longint'(ps >>> w); end
      3'd2: begin ps = sa * longint'(ub); r = longint'(ps >>> w); end
      3'd3: begin pu = ua * ub;           r = pu >> w; end
      3'd4: if (ub == 0) r = mask; else if (sa == min_s && sb == -1) r = ua; else r = longint'(sa / sb);
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: if (ub == 0) r = ua; else if (sa == min_s && sb == -1) r = 0; else r = longint'(sa % sb);
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Cycles from the accept edge to the done cycle.
  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int w, input bit fast);
    logic [31:0] m, am, bm;
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am = a & m;
    bm = b & m;
    if (o[2] && bm == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && am == (32'd1 << (w - 1)) && bm == m) return 1;
    if (!o[2] && fast) return 1;
    return w;
  endfunction

  // Issue one op on an idle unit, then check latency, busy span, held result and done pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] got);
    int w, lat, cyc, nbusy, changed;
    bit seen;
    logic [31:0] exp, prev;
    w     = (sel == 2) ? 16 : 32;
    exp   = ref_res(o, a, b, w);
    lat   = ref_lat(o, a, b, w, sel == 1);
    @(negedge clk);
    prev  = result_m;
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); op1 = $urandom; op2 = $urandom;
    seen = 1'b0; cyc = 0; nbusy = 0; changed = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done_m) seen = 1'b1;
      else begin
        if (busy_m) nbusy++;
        if (result_m !== prev) changed++;
      end
    end
    chk($sformatf("%s_lat", tag), 32'(cyc), 32'(lat));
    chk($sformatf("%s_busy_cnt", tag), 32'(nbusy), 32'(lat - 1));
    chk($sformatf("%s_hold", tag), 32'(changed), 32'd0);
    chk($sformatf("%s_busy_at_done", tag), {31'd0, busy_m}, 32'd0);
    chk($sformatf("%s_res", tag), result_m, exp);
    got = result_m;
    @(negedge clk);
    chk($sformatf("%s_pulse", tag), {31'd0, done_m}, 32'd0);
    chk($sformatf("%s_keep", tag), result_m, exp);
  endtask

  // Start held high with fresh operands every cycle; only IDLE-edge operands count.
  task automatic handshake(input string tag, input int ncyc);
    int w, next_acc, done_edge, lat;
    logic [31:0] exp_r, ca, cb;
    logic [2:0] co;
    bit exp_done;
    w = (sel == 2) ? 16 : 32;
    next_acc = 0; done_edge = -1; exp_r = 32'd0;
    @(negedge clk);
    for (int n = 0; n < ncyc + 40; n++) begin
      co = 3'($urandom);
      ca = $urandom;
      cb = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      start = (n < ncyc); op = co; op1 = ca; op2 = cb;
      @(posedge clk);
      if (n < ncyc && n == next_acc) begin
        exp_r     = ref_res(co, ca, cb, w);
        lat       = ref_lat(co, ca, cb, w, sel == 1);
        done_edge = n + lat - 1;
        next_acc  = n + lat;
      end
      @(negedge clk);
      exp_done = (n == done_edge);
      chk($sformatf("%s_done", tag), {31'd0, done_m}, {31'd0, exp_done});
      if (exp_done) chk($sformatf("%s_res", tag), result_m, exp_r);
    end
    start = 1'b0;
  endtask

  task automatic random_ops(input int count);
    logic [31:0] a, b, m, got;
    logic [2:0] o;
    int r;
    m = (sel == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    for (int i = 0; i < count; i++) begin
      o = 3'($urandom);
      a = $urandom & m;
      b = $urandom & m;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = (m >> 1) + 32'd1; b = m; end
      if (r == 2) b = $urandom_range(1, 15);
      run_op($sformatf("rnd%0d_op%0d", sel, o), o, a, b, got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, held;
    int dcnt;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", {31'd0, busy_m}, 32'd0);
      chk("rst_done", {31'd0, done_m}, 32'd0);
      chk("rst_result", result_m, 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, got);
    chk("divu_100_7_val", got, 32'd14);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; op = 3'd5; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy_m}, 32'd0);
    chk("rstmid_done", {31'd0, done_m}, 32'd0);
    chk("rstmid_result", result_m, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m) dcnt++;
    end
    chk("rstmid_nodone", 32'(dcnt), 32'd0);

    // Directed W=32 vectors
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, got);       chk("div_m7_2_val", got, 32'hFFFF_FFFD);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, got);       chk("rem_m7_2_val", got, 32'hFFFF_FFFF);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, got); chk("mulh_min_val", got, 32'h4000_0000);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got); chk("mulhu_max_val", got, 32'hFFFF_FFFE);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'd2, got);      chk("mulhsu_m1_val", got, 32'hFFFF_FFFF);
    run_op("mul_lo", 3'd0, 32'h1234_5678, 32'h10, got);        chk("mul_lo_val", got, 32'h2345_6780);
    run_op("divu_z", 3'd5, 32'd55, 32'd0, got);                chk("divu_z_val", got, 32'hFFFF_FFFF);
    run_op("remu_z", 3'd7, 32'd55, 32'd0, got);                chk("remu_z_val", got, 32'd55);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, got); chk("div_ovf_val", got, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, got); chk("rem_ovf_val", got, 32'd0);

    // Flush in BUSY at cycle 5 of a DIV
    run_op("div_1000_3", 3'd4, 32'd1000, 32'd3, got);
    held = got;
    @(negedge clk);
    start = 1'b1; op = 3'd4; op1 = 32'hFFFF_FF9C; op2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy", {31'd0, busy_m}, 32'd0);
    chk("flush_done", {31'd0, done_m}, 32'd0);
    chk("flush_result", result_m, held);
    run_op("after_flush", 3'd5, 32'd1000, 32'd10, got);        chk("after_flush_val", got, 32'd100);

    // Flush in IDLE blocks a start
    held = result_m;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; op1 = 32'd9; op2 = 32'd0;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idleflush_done", {31'd0, done_m}, 32'd0);
    chk("idleflush_busy", {31'd0, busy_m}, 32'd0);
    chk("idleflush_result", result_m, held);

    random_ops(12);
    handshake("hs32", 200);

    sel = 1;
    run_op("fast_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got); chk("fast_mulhu_val", got, 32'hFFFF_FFFE);
    run_op("fast_div", 3'd4, 32'hFFFF_FFF9, 32'd2, got);       chk("fast_div_val", got, 32'hFFFF_FFFD);
    random_ops(30);
    handshake("hsfast", 100);

    sel = 2;
    run_op("w16_div", 3'd4, 32'hFFF9, 32'd2, got);             chk("w16_div_val", got, 32'h0000_FFFD);
    run_op("w16_rem", 3'd6, 32'hFFF9, 32'd2, got);             chk("w16_rem_val", got, 32'h0000_FFFF);
    run_op("w16_mulh", 3'd1, 32'h8000, 32'h8000, got);         chk("w16_mulh_val", got, 32'h0000_4000);
    run_op("w16_mulhu", 3'd3, 32'hFFFF, 32'hFFFF, got);        chk("w16_mulhu_val", got, 32'h0000_FFFE);
    run_op("w16_mulhsu", 3'd2, 32'hFFFF, 32'd2, got);          chk("w16_mulhsu_val", got, 32'h0000_FFFF);
    run_op("w16_mul", 3'd0, 32'h1234, 32'h10, got);            chk("w16_mul_val", got, 32'h0000_2340);
    run_op("w16_ovf", 3'd4, 32'h8000, 32'hFFFF, got);          chk("w16_ovf_val", got, 32'h0000_8000);
    random_ops(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
